// File: rtl/core_seq_pkg.sv
// Shared encodings for the NPC core sequencer: FSM state codes and the opcodes it decodes.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT_I = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/core_seq_timer.sv
// Bus-wait watchdog: counts stalled cycles; expired is combinational on count==TIMEOUT.
// Zero-cycle flag latency, no backpressure; clear has priority over enable.
module seq_timer #(
  parameter int TMR_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == TMR_W'(TIMEOUT));

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: FSM, bus handshakes, writeback gating, retire counter.
// Architectural strobes (rf_we, pc_we) fire only in WB; HALT/ERR are absorbing until rst.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int TMR_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  output logic        ir_we_o,
  input  logic [6:0]  opcode_i,
  input  logic        we_i,
  input  logic        jump_branch_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_rvalid_i,
  output logic        rf_we_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic [31:0] retire_cnt_o,
  output logic        halt_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  state_t state, state_next;
  logic   handshake, bus_wait, expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // A handshake arriving in the timeout cycle takes priority over ERR.
  always_comb begin
    state_next = state;
    handshake  = 1'b0;
    bus_wait   = 1'b0;
    case (state)
      ST_FETCH: begin
        bus_wait  = 1'b1;
        handshake = imem_gnt_i;
        if (handshake)    state_next = ST_WAIT_I;
        else if (expired) state_next = ST_ERR;
      end
      ST_WAIT_I: begin
        bus_wait  = 1'b1;
        handshake = imem_rvalid_i;
        if (handshake)    state_next = ST_DECODE;
        else if (expired) state_next = ST_ERR;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (opcode_i == OP_SYSTEM)                             state_next = ST_HALT;
        else if (opcode_i == OP_LOAD || opcode_i == OP_STORE)  state_next = ST_MEM;
        else                                                   state_next = ST_WB;
      end
      ST_MEM: begin
        bus_wait  = 1'b1;
        handshake = dmem_rvalid_i;
        if (handshake)    state_next = ST_WB;
        else if (expired) state_next = ST_ERR;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  seq_timer #(
    .TMR_W   (TMR_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_next != state),
    .en      (bus_wait && !handshake),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_o <= '0;
    end else if (state == ST_WB) begin
      retire_cnt_o <= retire_cnt_o + 32'd1;
    end
  end

  assign imem_req_o = (state == ST_FETCH);
  assign ir_we_o    = (state == ST_WAIT_I) && imem_rvalid_i;
  assign dmem_req_o = (state == ST_MEM);
  assign dmem_we_o  = (state == ST_MEM) && (opcode_i == OP_STORE);
  assign rf_we_o    = (state == ST_WB) && (we_i || opcode_i == OP_LOAD);
  assign pc_we_o    = (state == ST_WB);
  assign pc_sel_o   = (state == ST_WB) && jump_branch_i;
  assign halt_o     = (state == ST_HALT);
  assign err_o      = (state == ST_ERR);
  assign state_o    = state;

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq with hand-computed expectations.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, ir_we_o;
  logic [6:0]  opcode_i;
  logic        we_i, jump_branch_i;
  logic        dmem_req_o, dmem_we_o, dmem_rvalid_i;
  logic        rf_we_o, pc_we_o, pc_sel_o;
  logic [31:0] retire_cnt_o;
  logic        halt_o, err_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int pc_we_pulses = 0;
  int rf_we_pulses = 0;

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] SYS  = 7'b1110011;

  core_seq #(.TMR_W(8), .TIMEOUT(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .ir_we_o       (ir_we_o),
    .opcode_i      (opcode_i),
    .we_i          (we_i),
    .jump_branch_i (jump_branch_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_rvalid_i (dmem_rvalid_i),
    .rf_we_o       (rf_we_o),
    .pc_we_o       (pc_we_o),
    .pc_sel_o      (pc_sel_o),
    .retire_cnt_o  (retire_cnt_o),
    .halt_o        (halt_o),
    .err_o         (err_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && pc_we_o) pc_we_pulses++;
    if (!rst && rf_we_o) rf_we_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH with zero-wait imem, drive the instruction and stop in the EXEC cycle.
  task automatic fetch_to_exec(input logic [6:0] op, input logic we, input logic jb);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    #1;
    chk("wait_i_state", state_o, 3'd1);
    chk("ir_we", ir_we_o, 1'b1);
    step();
    imem_rvalid_i = 1'b0;
    opcode_i = op; we_i = we; jump_branch_i = jb;
    #1;
    chk("decode_state", state_o, 3'd2);
    step();
    chk("exec_state", state_o, 3'd3);
  endtask

  initial begin
    imem_gnt_i = 0; imem_rvalid_i = 0; dmem_rvalid_i = 0;
    opcode_i = '0; we_i = 0; jump_branch_i = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_state", state_o, 3'd0);
    chk("rst_imem_req", imem_req_o, 1'b1);
    chk("rst_retire", retire_cnt_o, 32'd0);
    chk("rst_outs", {ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, pc_sel_o, halt_o, err_o}, 8'h00);

    // addi, 5 cycles
    imem_rvalid_i = 1'b1;
    #1;
    chk("rvalid_in_fetch_ignored", ir_we_o, 1'b0);
    imem_rvalid_i = 1'b0;
    fetch_to_exec(ADDI, 1'b1, 1'b0);
    step();
    chk("addi_wb_state", state_o, 3'd5);
    chk("addi_wb_strobes", {rf_we_o, pc_we_o, pc_sel_o}, 3'b110);
    step();
    chk("addi_back_fetch", state_o, 3'd0);
    chk("addi_retire", retire_cnt_o, 32'd1);
    chk("addi_pc_pulses", pc_we_pulses, 1);

    // load, response after 3 wait cycles
    fetch_to_exec(LD, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_req", {dmem_req_o, dmem_we_o, state_o}, {2'b10, 3'd4});
      step();
    end
    dmem_rvalid_i = 1'b1;
    #1;
    chk("ld_mem_req_4th", {dmem_req_o, dmem_we_o}, 2'b10);
    step();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("ld_wb_state", state_o, 3'd5);
    chk("ld_wb_rf_we", rf_we_o, 1'b1);
    step();
    chk("ld_retire", retire_cnt_o, 32'd2);

    // store then taken beq
    fetch_to_exec(ST, 1'b0, 1'b0);
    step();
    dmem_rvalid_i = 1'b1;
    #1;
    chk("st_mem_we", {dmem_req_o, dmem_we_o}, 2'b11);
    step();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("st_wb_strobes", {rf_we_o, pc_we_o, pc_sel_o}, 3'b010);
    step();
    fetch_to_exec(BEQ, 1'b0, 1'b1);
    step();
    chk("beq_wb_strobes", {rf_we_o, pc_we_o, pc_sel_o}, 3'b011);
    step();
    chk("beq_retire", retire_cnt_o, 32'd4);
    jump_branch_i = 1'b0;

    // fetch timeout: 256 FETCH cycles then ERR
    for (int i = 0; i < 255; i++) step();
    chk("to_still_fetch", state_o, 3'd0);
    step();
    chk("to_err_state", state_o, 3'd7);
    chk("to_err_flag", err_o, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("to_err_sticky", {err_o, imem_req_o, state_o}, {2'b10, 3'd7});

    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("err_rst_state", state_o, 3'd0);
    chk("err_rst_retire", retire_cnt_o, 32'd0);

    // grant arriving at count 255 wins over timeout
    for (int i = 0; i < 255; i++) step();
    imem_gnt_i = 1'b1;
    #1;
    chk("gnt255_fetch", state_o, 3'd0);
    step();
    imem_gnt_i = 1'b0;
    #1;
    chk("gnt255_wait_i", state_o, 3'd1);

    // SYSTEM opcode halts
    imem_rvalid_i = 1'b1;
    step();
    imem_rvalid_i = 1'b0;
    opcode_i = SYS; we_i = 1'b0;
    step();
    step();
    chk("halt_state", state_o, 3'd6);
    chk("halt_flag", {halt_o, imem_req_o, pc_we_o}, 3'b100);
    for (int i = 0; i < 4; i++) step();
    chk("halt_sticky", {halt_o, imem_req_o, state_o}, {2'b10, 3'd6});
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("halt_rst", {halt_o, state_o}, {1'b0, 3'd0});
    chk("halt_rst_retire", retire_cnt_o, 32'd0);

    // reset in the middle of MEM, late response ignored
    fetch_to_exec(LD, 1'b1, 1'b0);
    step();
    chk("mid_mem_state", state_o, 3'd4);
    rst = 1'b1; step(); rst = 1'b0;
    dmem_rvalid_i = 1'b1;
    #1;
    chk("mid_mem_rst_state", state_o, 3'd0);
    chk("mid_mem_late", {rf_we_o, pc_we_o, dmem_req_o}, 3'b000);
    step();
    chk("mid_mem_late2", {rf_we_o, pc_we_o, state_o}, {2'b00, 3'd0});
    dmem_rvalid_i = 1'b0;

    chk("total_pc_pulses", pc_we_pulses, 4);
    chk("total_rf_pulses", rf_we_pulses, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle instruction sequencer for the NPC core. It steps each instruction through fetch, decode, execute, optional memory access and writeback, and it owns the instruction- and data-bus request handshakes. It gates the register-file write enable and PC update that the combinational control unit produces, so no architectural state changes outside the writeback cycle. It also counts retired instructions and flags halt (SYSTEM opcode) and bus-timeout error.

## Interface
Parameters:
- TMR_W, 8, width of bus-wait watchdog counter
- TIMEOUT, 255, max wait cycles in FETCH/WAIT_I/MEM before ERR (must fit TMR_W)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req_o  out  1  instruction fetch request
- imem_gnt_i  in  1  fetch request accepted
- imem_rvalid_i  in  1  instruction word valid
- ir_we_o  out  1  load instruction register
- opcode_i  in  7  opcode from IR (valid DECODE onward)
- we_i  in  1  register write enable from control unit
- jump_branch_i  in  1  taken jump/branch from control unit/BCU
- dmem_req_o  out  1  data request, held until response
- dmem_we_o  out  1  1 = store, 0 = load
- dmem_rvalid_i  in  1  data response/ack (load data or store done)
- rf_we_o  out  1  gated register-file write
- pc_we_o  out  1  PC update strobe
- pc_sel_o  out  1  1 = branch/jump target, 0 = PC+4
- retire_cnt_o  out  32  retired-instruction count
- halt_o  out  1  sticky halt
- err_o  out  1  sticky bus timeout
- state_o  out  3  current state (debug)

## Operation
- States (encoding): FETCH=0, WAIT_I=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- FETCH: imem_req_o=1; imem_gnt_i → WAIT_I, else stay.
- WAIT_I: imem_rvalid_i → ir_we_o=1 this cycle, → DECODE; else stay. rvalid seen in FETCH is ignored.
- DECODE: one cycle, → EXEC.
- EXEC: opcode 1110011 → HALT; 0000011 (load) or 0100011 (store) → MEM; anything else → WB.
- MEM: dmem_req_o=1, dmem_we_o=(opcode==store); dmem_rvalid_i → WB.
- WB: pc_we_o=1, pc_sel_o=jump_branch_i, rf_we_o=we_i | (opcode==load); retire_cnt +1; → FETCH.
- HALT, ERR: absorbing until rst; halt_o / err_o =1; no requests, no strobes.
- Watchdog: clears on every state change. Increments each cycle spent in FETCH, WAIT_I or MEM without the exiting handshake. At count==TIMEOUT with no handshake → ERR. A handshake in the same cycle as the timeout wins.
- retire_cnt wraps 0xFFFF_FFFF → 0.
- Unknown opcodes retire normally. we_i from the control unit is 0 for them, so there is no RF write.

## Timing
- Reset (rst high at edge): state=FETCH, retire_cnt=0, watchdog=0. On the next cycle all outputs are 0 except imem_req_o=1 and state_o=0.
- rst dominates every state, including MEM and HALT/ERR. Responses arriving after reset are ignored unless in the matching wait state.
- imem_req_o, dmem_req_o, dmem_we_o, halt_o, err_o and state_o decode from the state register (plus opcode_i for dmem_we_o).
- ir_we_o is Mealy (WAIT_I & imem_rvalid_i). pc_we_o, pc_sel_o and rf_we_o are asserted only in WB.
- Minimum latency with zero-wait bus: ALU/branch/jump takes 5 cycles (FETCH, WAIT_I, DECODE, EXEC, WB). Load/store with 1-cycle response takes 6 cycles.
- Exactly one pc_we_o pulse and one retire increment per retired instruction. These never occur in HALT or ERR.

## Structure
- Add the state encodings and opcode constants (OP_LOAD, OP_STORE, OP_SYSTEM) to the shared define header.
- Sub-module seq_timer: TMR_W-bit watchdog with clear, enable and expired outputs.
- core_seq holds the FSM, output decode and the retire counter.

## Test plan
- Zero-wait bus, addi (opcode 0010011, we_i=1): retires in 5 cycles; rf_we_o and pc_we_o each pulse once; pc_sel_o=0; retire_cnt 0→1.
- Load with dmem_rvalid_i delayed 3 cycles: dmem_req_o held 4 cycles with dmem_we_o=0; then WB with rf_we_o=1.
- Store followed by beq with jump_branch_i=1: store gives dmem_we_o=1 and rf_we_o=0 in WB. beq gives pc_sel_o=1 in WB.
- imem_gnt_i held low, TIMEOUT=255: ERR reached after 256 FETCH cycles; err_o=1 sticky. Gnt asserted at count 255 instead → WAIT_I.
- Opcode 1110011 → HALT after EXEC; halt_o=1; no further imem_req_o. rst=1 returns to FETCH with retire_cnt=0.
- rst asserted mid-MEM: next cycle FETCH; a late dmem_rvalid_i causes no rf_we_o/pc_we_o.
